pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Converts single-cycle pulses (such as those from the edge detector, button parser or UART strobes) into held levels of fixed duration, one independent channel per bit. It sits between pulse-producing logic and slow consumers such as LEDs, external pins and human-visible indicators. When each stretched level ends, it produces a one-cycle completion pulse.

## Interface
- `width`, default 1: number of independent channels.
- `pulse_cycles`, default 4: length of the stretched level in clock cycles. Must be ≥ 1.
- `retrigger`, default 1: behaviour of a trigger that arrives while a channel is active.
  - 1: reload the counter.
  - 0: ignore the trigger.
- `clk`, input, 1 bit: the only clock. All logic is on its rising edge.
- `rst`, input, 1 bit: reset. It is synchronous and active-high.
- `pulse_in`, input, `width` bits: per-channel trigger, sampled every cycle and treated as level-sensitive.
- `level_out`, output, `width` bits: per-channel stretched level, registered.
- `done_pulse`, output, `width` bits: per-channel one-cycle pulse marking the end of a stretched level, registered.

## Operation
- Each channel holds a down-counter `cnt` with width `$clog2(pulse_cycles+1)`.
- `level_out[i]` is the registered value of `(cnt != 0)`.
- Channel states:
  - IDLE: `cnt == 0`.
  - ACTIVE: `cnt != 0`.
- IDLE with `pulse_in[i]=1`: load `cnt = pulse_cycles` and go to ACTIVE.
- ACTIVE with `pulse_in[i]=0`: decrement `cnt`. When `cnt` reaches 0, go to IDLE.
- ACTIVE with `pulse_in[i]=1`:
  - If `retrigger=1`: reload `cnt = pulse_cycles`. This applies in every ACTIVE cycle, including the last (`cnt==1`), so the level continues unbroken.
  - If `retrigger=0`: ignore the trigger and keep decrementing.
- `done_pulse[i]` is 1 for exactly one cycle, in the first cycle where `level_out[i]` is 0 after being 1. It is never asserted otherwise.
- Channels are fully independent. Simultaneous triggers on different bits do not interact.
- Consequence of level sensitivity, with `pulse_in` held high continuously:
  - `retrigger=1`: `level_out` stays high until `pulse_in` falls, then stays high for a further `pulse_cycles` cycles.
  - `retrigger=0`: `level_out` runs `pulse_cycles` high, 1 low (`done_pulse` asserted), then repeats.
- Reset, including reset in the middle of a level:
  - `cnt`, `level_out` and `done_pulse` go to 0 on the next edge.
  - No `done_pulse` is generated for a level cut short by reset.
  - `pulse_in` is ignored in any cycle where `rst=1`.

## Timing
- Reset values: `level_out = 0`, `done_pulse = 0` for all bits.
- Trigger sampled high at edge t (`pulse_in=1` in cycle t-1/t, IDLE, no further triggers):
  - `level_out=1` in cycles t+1 … t+`pulse_cycles`.
  - `done_pulse=1` in cycle t+`pulse_cycles`+1.
- Latency from trigger to level: 1 cycle.
- High time is exactly `pulse_cycles` cycles per isolated trigger. With `pulse_cycles=1` this is a registered copy of the pulse.
- Retrigger (`retrigger=1`) with last trigger at edge t: the level ends after cycle t+`pulse_cycles`, independent of earlier triggers.
- Minimum low time between levels with `retrigger=0`: 1 cycle.
- There is no combinational path from input to output.

## Structure
- Sub-module `pulse_stretcher_channel`:
  - one counter, the level register and the done register;
  - parameters `pulse_cycles` and `retrigger`.
- The top module instantiates `width` copies in a generate loop.
- No shared package entries. The counter width is a localparam derived from `pulse_cycles` inside the channel.
- An elaboration-time check rejects `pulse_cycles < 1`.

## Test plan
Unless noted: `width=2`, `pulse_cycles=4`.
1. Reset: hold `rst=1` for 3 cycles with `pulse_in=2'b11` → `level_out=0` and `done_pulse=0` throughout. After release with `pulse_in=0`, both stay 0.
2. Isolated pulse: `pulse_in[0]=1` for one cycle at edge 10 → `level_out[0]=1` in cycles 11–14; `done_pulse[0]=1` only in cycle 15; `level_out[1]` stays 0.
3. Retrigger, `retrigger=1`: pulses at edges 10 and 13 → `level_out[0]` high in cycles 11–17 with no gap; `done_pulse` in cycle 18 only.
4. Ignore, `retrigger=0`: pulses at edges 10 and 13 → `level_out[0]` high in cycles 11–14; `done_pulse` in cycle 15. Held-high `pulse_in` → pattern of 4 high, 1 low repeats.
5. Reset mid-level: trigger at edge 10, `rst=1` at edge 12 → `level_out=0` from cycle 13; no `done_pulse` at any time.
6. Independence and edge case: `pulse_cycles=1`, pulses on bit 0 at edge 5 and bit 1 at edge 6 → `level_out` = 01 in cycle 6 and 10 in cycle 7; `done_pulse` = 01 in cycle 7 and 10 in cycle 8.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// ============================================================================
//  Module      : pulse_stretcher_pkg
//  Description : Channel state encoding for the pulse stretcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_stretcher_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } chan_state_e;

endpackage : pulse_stretcher_pkg

`default_nettype wire

// File: rtl/pulse_stretcher_channel.sv
// ============================================================================
//  Module      : pulse_stretcher_channel
//  Description : One stretcher channel: down-counter, level and done registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretcher_channel
   import pulse_stretcher_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter bit RETRIGGER    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pulse_in,
   output logic level_out,
   output logic done_pulse
);

   localparam int               CNT_W  = $clog2(PULSE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_ZERO = '0;

   generate
      if (PULSE_CYCLES < 1) begin : g_bad_pulse_cycles
         $error("pulse_stretcher_channel: PULSE_CYCLES must be >= 1");
      end
   endgenerate

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_level_nxt;
   logic             r_level;
   logic             r_done;
   chan_state_e      w_state;

   assign w_state = (r_cnt != c_ZERO) ? ST_ACTIVE : ST_IDLE;

   always_comb begin
      w_cnt_nxt = r_cnt;
      case (w_state)
         ST_IDLE: begin
            if (pulse_in) w_cnt_nxt = c_LOAD;
         end
         ST_ACTIVE: begin
            if (pulse_in && RETRIGGER) w_cnt_nxt = c_LOAD;
            else                       w_cnt_nxt = r_cnt - c_ONE;
         end
         default: w_cnt_nxt = c_ZERO;
      endcase
   end

   assign w_level_nxt = (w_cnt_nxt != c_ZERO);

   // Level mirrors the next count so the output rises on the trigger edge itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= c_ZERO;
         r_level <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_done  <= r_level & ~w_level_nxt;
      end
   end

   assign level_out  = r_level;
   assign done_pulse = r_done;

endmodule : pulse_stretcher_channel

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
//  Module      : pulse_stretcher
//  Description : WIDTH independent pulse-to-level stretchers with done strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int WIDTH        = 1,
   parameter int PULSE_CYCLES = 4,
   parameter bit RETRIGGER    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pulse_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] done_pulse
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         pulse_stretcher_channel #(
            .PULSE_CYCLES (PULSE_CYCLES),
            .RETRIGGER    (RETRIGGER)
         ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .pulse_in   (pulse_in[gi]),
            .level_out  (level_out[gi]),
            .done_pulse (done_pulse[gi])
         );
      end
   endgenerate

endmodule : pulse_stretcher

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
//  Module      : tb_pulse_stretcher
//  Description : Directed self-checking bench for pulse_stretcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] pin_a = '0, pin_b = '0, pin_c = '0;
   logic [1:0] lvl_a, lvl_b, lvl_c;
   logic [1:0] dn_a, dn_b, dn_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // A: retrigger on, B: retrigger off, C: single-cycle stretch
   pulse_stretcher #(.WIDTH(2), .PULSE_CYCLES(4), .RETRIGGER(1'b1)) dut_a (
      .clk(clk), .rst(rst), .pulse_in(pin_a), .level_out(lvl_a), .done_pulse(dn_a));
   pulse_stretcher #(.WIDTH(2), .PULSE_CYCLES(4), .RETRIGGER(1'b0)) dut_b (
      .clk(clk), .rst(rst), .pulse_in(pin_b), .level_out(lvl_b), .done_pulse(dn_b));
   pulse_stretcher #(.WIDTH(2), .PULSE_CYCLES(1), .RETRIGGER(1'b1)) dut_c (
      .clk(clk), .rst(rst), .pulse_in(pin_c), .level_out(lvl_c), .done_pulse(dn_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pin_a = 2'b11; pin_b = 2'b11; pin_c = 2'b11;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({lvl_a, lvl_b, lvl_c, dn_a, dn_b, dn_c} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold cyc%0d: lvl=%b/%b/%b done=%b/%b/%b expected all 0",
                     i, lvl_a, lvl_b, lvl_c, dn_a, dn_b, dn_c);
         end
      end
      rst = 1'b0; pin_a = '0; pin_b = '0; pin_c = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({lvl_a, lvl_b, lvl_c, dn_a, dn_b, dn_c} !== 12'h000) begin
            errors++;
            $display("FAIL reset_release cyc%0d: lvl=%b/%b/%b done=%b/%b/%b expected all 0",
                     i, lvl_a, lvl_b, lvl_c, dn_a, dn_b, dn_c);
         end
      end
   endtask

   task automatic test_isolated();
      logic [1:0] el [0:6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
      logic [1:0] ed [0:6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
      pin_a = 2'b01;
      for (int i = 0; i < 7; i++) begin
         tick();
         pin_a = 2'b00;
         checks++;
         if (lvl_a !== el[i] || dn_a !== ed[i]) begin
            errors++;
            $display("FAIL isolated cyc%0d: level=%b done=%b expected level=%b done=%b",
                     i, lvl_a, dn_a, el[i], ed[i]);
         end
      end
   endtask

   task automatic test_retrigger();
      logic [1:0] el [0:9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                               2'b00, 2'b00, 2'b00};
      logic [1:0] ed [0:9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                               2'b01, 2'b00, 2'b00};
      for (int i = 0; i < 10; i++) begin
         pin_a = (i == 0 || i == 3) ? 2'b01 : 2'b00;
         tick();
         checks++;
         if (lvl_a !== el[i] || dn_a !== ed[i]) begin
            errors++;
            $display("FAIL retrigger cyc%0d: level=%b done=%b expected level=%b done=%b",
                     i, lvl_a, dn_a, el[i], ed[i]);
         end
      end
      pin_a = 2'b00;
   endtask

   task automatic test_ignore();
      logic [1:0] el [0:6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
      logic [1:0] ed [0:6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
      for (int i = 0; i < 7; i++) begin
         pin_b = (i == 0 || i == 3) ? 2'b01 : 2'b00;
         tick();
         checks++;
         if (lvl_b !== el[i] || dn_b !== ed[i]) begin
            errors++;
            $display("FAIL ignore cyc%0d: level=%b done=%b expected level=%b done=%b",
                     i, lvl_b, dn_b, el[i], ed[i]);
         end
      end
      // Held-high trigger: 4 high, 1 low with done, repeating.
      pin_b = 2'b10;
      for (int i = 0; i < 10; i++) begin
         logic el1, ed1;
         tick();
         el1 = ((i % 5) != 4);
         ed1 = ((i % 5) == 4);
         checks++;
         if (lvl_b !== {el1, 1'b0} || dn_b !== {ed1, 1'b0}) begin
            errors++;
            $display("FAIL ignore_held cyc%0d: level=%b done=%b expected level=%b done=%b",
                     i, lvl_b, dn_b, {el1, 1'b0}, {ed1, 1'b0});
         end
      end
      pin_b = 2'b00;
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic test_reset_mid();
      logic [1:0] el [0:5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 6; i++) begin
         pin_a = (i == 0) ? 2'b01 : 2'b00;
         rst   = (i == 2);
         tick();
         checks++;
         if (lvl_a !== el[i] || dn_a !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid cyc%0d: level=%b done=%b expected level=%b done=00",
                     i, lvl_a, dn_a, el[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_independent();
      logic [1:0] el [0:4] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
      logic [1:0] ed [0:4] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
      for (int i = 0; i < 5; i++) begin
         pin_c = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : 2'b00;
         tick();
         checks++;
         if (lvl_c !== el[i] || dn_c !== ed[i]) begin
            errors++;
            $display("FAIL independent cyc%0d: level=%b done=%b expected level=%b done=%b",
                     i, lvl_c, dn_c, el[i], ed[i]);
         end
      end
      pin_c = 2'b00;
   endtask

   initial begin
      test_reset();
      test_isolated();
      test_retrigger();
      test_ignore();
      test_reset_mid();
      test_independent();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pulse_stretcher

`default_nettype wire
